// File: rtl/dm_param_if.sv
// Request/response bundle between the memory stage (master) and the data memory (slave).
interface dm_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0]   addr;
   logic                re;
   logic                we;
   logic [DATA_W/8-1:0] be;
   logic [DATA_W-1:0]   wrt_data;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_vld;
   logic                rdy;
   logic                err;

   // The memory-stage side issues requests and consumes results
   modport master (
      output addr, re, we, be, wrt_data,
      input  rd_data, rd_vld, rdy, err
   );

   // The memory side accepts requests and produces results
   modport slave (
      input  addr, re, we, be, wrt_data,
      output rd_data, rd_vld, rdy, err
   );
endinterface

// File: rtl/dm_param.sv
// Parametrised single-port data memory with byte-lane writes, a 1- or 2-cycle
// read pipeline, error reporting for illegal/out-of-range requests and an
// optional post-reset clear sequencer that zeroes the array before accepting work.
module dm_param #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 16,
   parameter int DEPTH        = 1024,
   parameter int RD_LAT       = 1,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input logic     clk,
   input logic     rst,
   dm_param_if.slave bus
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_ptr;
   logic              rdy_r;
   logic              err_r;
   logic              rd_vld_r;
   logic [DATA_W-1:0] rd_data_r;
   logic              s1_vld;
   logic [DATA_W-1:0] s1_data;

   // The array is deliberately left out of the reset domain; it is zeroed by CLEAR
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              rd_any;
   logic              wr_ok;
   logic              req_err;
   logic              clr_we;
   logic [DATA_W-1:0] rd_word;

   // Decode the request presented this cycle; only honoured while rdy is high.
   // Out-of-range reads still travel down the pipeline, but carrying zero.
   always_comb begin
      in_range = ({1'b0, bus.addr} < DEPTH_EXT);
      idx      = bus.addr[IDX_W-1:0];
      rd_any   = rdy_r & bus.re & ~bus.we;
      wr_ok    = rdy_r & bus.we & ~bus.re & in_range;
      req_err  = rdy_r & ((bus.re & bus.we) | ((bus.re | bus.we) & ~in_range));
      clr_we   = (state == CLEAR);
      rd_word  = '0;
      if (in_range) begin
         rd_word = mem[idx];
      end
   end

   // Array write port: the clear sequencer has the port to itself during CLEAR,
   // otherwise accepted writes update only the enabled byte lanes
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.be[i]) begin
               mem[idx][8*i +: 8] <= bus.wrt_data[8*i +: 8];
            end
         end
      end
   end

   // Control FSM: sweep the clear pointer, then sit in IDLE with rdy raised a
   // cycle later so the first accepted request never races the final clear write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR_ON_RST ? CLEAR : IDLE;
         clr_ptr <= '0;
         rdy_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         err_r <= req_err;
         case (state)
            CLEAR: begin
               rdy_r <= 1'b0;
               if (clr_ptr == LAST_IDX) begin
                  state   <= IDLE;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + IDX_W'(1);
               end
            end
            IDLE: begin
               rdy_r <= 1'b1;
            end
            default: begin
               state <= IDLE;
               rdy_r <= 1'b0;
            end
         endcase
      end
   end

   // Read pipeline: the array is sampled at the request edge; with two-cycle
   // latency the word waits in a stage register, so a later write to the same
   // address cannot leak into an already-issued read. rd_data only moves on a pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_data   <= '0;
         rd_vld_r  <= 1'b0;
         rd_data_r <= '0;
      end else if (RD_LAT == 2) begin
         s1_vld   <= rd_any;
         if (rd_any) begin
            s1_data <= rd_word;
         end
         rd_vld_r <= s1_vld;
         if (s1_vld) begin
            rd_data_r <= s1_data;
         end
      end else begin
         s1_vld   <= 1'b0;
         rd_vld_r <= rd_any;
         if (rd_any) begin
            rd_data_r <= rd_word;
         end
      end
   end

   assign bus.rd_data = rd_data_r;
   assign bus.rd_vld  = rd_vld_r;
   assign bus.rdy     = rdy_r;
   assign bus.err     = err_r;

endmodule

// File: tb/tb_dm_param.sv
// Scoreboard bench for dm_param: two instances (RD_LAT=1 and RD_LAT=2) receive
// identical randomized and directed traffic; a word-level memory model predicts
// every rd_vld/err pulse and the cycle it must appear in.
module tb_dm_param;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 1024;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   exp_rd_t     rd_q  [2][$];
   int          err_q [2][$];
   logic [15:0] last_data [2];
   logic [15:0] model [DEPTH];

   dm_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
   dm_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

   dm_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RST(1'b1)
   ) u_lat1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   dm_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RST(1'b1)
   ) u_lat2 (
      .clk(clk), .rst(rst), .bus(bus2.slave)
   );

   // Free-running clock and an edge counter used to timestamp expectations
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bound the whole run so a stuck DUT can never hang the simulation
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: actual run still active, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // Compare one DUT's outputs for the current cycle against its scoreboard queues
   task automatic checkOutput(input int d, input logic vld, input logic [15:0] data, input logic e);
      exp_rd_t x;
      int      ec;
      while (rd_q[d].size() > 0 && rd_q[d][0].cyc < cyc) begin
         x = rd_q[d].pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_rd_vld lat%0d: actual no pulse, required data %h at cycle %0d", d + 1, x.data, x.cyc);
      end
      while (err_q[d].size() > 0 && err_q[d][0] < cyc) begin
         ec = err_q[d].pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_err lat%0d: actual no pulse, required err at cycle %0d", d + 1, ec);
      end
      if (vld) begin
         checks++;
         if (rd_q[d].size() == 0 || rd_q[d][0].cyc != cyc) begin
            errors++;
            $display("[TB] FAIL unexpected_rd_vld lat%0d: actual pulse data %h at cycle %0d, required none", d + 1, data, cyc);
         end else begin
            x = rd_q[d].pop_front();
            if (data !== x.data) begin
               errors++;
               $display("[TB] FAIL rd_data lat%0d: actual %h, required %h at cycle %0d", d + 1, data, x.data, cyc);
            end
            last_data[d] = data;
         end
      end else begin
         checks++;
         if (data !== last_data[d]) begin
            errors++;
            $display("[TB] FAIL rd_data_hold lat%0d: actual %h, required %h at cycle %0d", d + 1, data, last_data[d], cyc);
         end
      end
      if (e) begin
         checks++;
         if (err_q[d].size() == 0 || err_q[d][0] != cyc) begin
            errors++;
            $display("[TB] FAIL unexpected_err lat%0d: actual err=1 at cycle %0d, required 0", d + 1, cyc);
         end else begin
            void'(err_q[d].pop_front());
         end
      end
   endtask

   // Monitor: sample both DUTs on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput(0, bus1.rd_vld, bus1.rd_data, bus1.err);
         checkOutput(1, bus2.rd_vld, bus2.rd_data, bus2.err);
      end
   end

   task automatic driveBus(input logic r, input logic w, input logic [15:0] a,
                           input logic [1:0] b, input logic [15:0] wd);
      bus1.re = r; bus1.we = w; bus1.addr = a; bus1.be = b; bus1.wrt_data = wd;
      bus2.re = r; bus2.we = w; bus2.addr = a; bus2.be = b; bus2.wrt_data = wd;
   endtask

   // Issue one request for the coming edge and record what the memory must do
   task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                                input logic [1:0] b, input logic [15:0] wd);
      int      e;
      exp_rd_t x;
      @(negedge clk);
      driveBus(r, w, a, b, wd);
      e = cyc + 1;
      if (r && w) begin
         for (int d = 0; d < 2; d++) err_q[d].push_back(e);
      end else if ((r || w) && int'(a) >= DEPTH) begin
         for (int d = 0; d < 2; d++) begin
            err_q[d].push_back(e);
            if (r) begin
               x.cyc  = e + d;
               x.data = 16'h0000;
               rd_q[d].push_back(x);
            end
         end
      end else if (r) begin
         for (int d = 0; d < 2; d++) begin
            x.cyc  = e + d;
            x.data = model[int'(a)];
            rd_q[d].push_back(x);
         end
      end else if (w) begin
         for (int i = 0; i < 2; i++) begin
            if (b[i]) model[int'(a)][8*i +: 8] = wd[8*i +: 8];
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         driveBus(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      end
   endtask

   // Drop expectations that can no longer occur because reset flushed them
   task automatic trimQueues();
      for (int d = 0; d < 2; d++) begin
         while (rd_q[d].size() > 0 && rd_q[d][rd_q[d].size() - 1].cyc > cyc)
            void'(rd_q[d].pop_back());
         while (err_q[d].size() > 0 && err_q[d][err_q[d].size() - 1] > cyc)
            void'(err_q[d].pop_back());
         last_data[d] = 16'h0000;
      end
   endtask

   // Pulse reset, then watch the clear sweep with junk requests on the bus.
   // abort_after > 0 stops partway through the sweep without measuring it.
   task automatic doReset(input int abort_after);
      int k0;
      int n;
      @(negedge clk);
      #1;
      rst = 1'b1;
      trimQueues();
      #1;
      checkVal("reset_outputs_lat1", {29'd0, bus1.rdy, bus1.rd_vld, bus1.err}, 32'd0);
      checkVal("reset_outputs_lat2", {29'd0, bus2.rdy, bus2.rd_vld, bus2.err}, 32'd0);
      checkVal("reset_rd_data_lat1", {16'd0, bus1.rd_data}, 32'd0);
      checkVal("reset_rd_data_lat2", {16'd0, bus2.rd_data}, 32'd0);
      driveBus(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      k0 = cyc;
      n  = 0;
      while (n < 3000) begin
         if (abort_after > 0 && n >= abort_after) break;
         @(negedge clk);
         if (bus1.rdy) break;
         driveBus(1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), 16'($urandom));
         n++;
      end
      driveBus(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      if (abort_after == 0) begin
         checkVal("clear_rdy_delay", 32'(cyc - (k0 + 1)), 32'(DEPTH));
         checkVal("clear_rdy_lat2", {31'd0, bus2.rdy}, 32'd1);
         for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      end
   endtask

   initial begin
      logic [15:0] a;
      logic        r;
      logic        w;
      int          kind;
      int          sel;

      last_data[0] = 16'h0000;
      last_data[1] = 16'h0000;
      driveBus(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
      repeat (2) @(negedge clk);
      $display("[TB] start");

      // Abort a clear halfway, then let a full sweep run
      doReset(500);
      doReset(0);

      // Cleared contents at the ends and middle of the array
      applyStimulus(1'b1, 1'b0, 16'd0, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd511, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd1023, 2'b00, 16'h0);
      idle(3);

      // Byte lanes
      applyStimulus(1'b0, 1'b1, 16'd3, 2'b11, 16'hA5A5);
      applyStimulus(1'b0, 1'b1, 16'd3, 2'b01, 16'h1234);
      applyStimulus(1'b0, 1'b1, 16'd3, 2'b00, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 16'd3, 2'b00, 16'h0);
      idle(3);

      // Back-to-back reads after back-to-back writes
      applyStimulus(1'b0, 1'b1, 16'd10, 2'b11, 16'h0011);
      applyStimulus(1'b0, 1'b1, 16'd11, 2'b11, 16'h0022);
      applyStimulus(1'b0, 1'b1, 16'd12, 2'b11, 16'h0033);
      applyStimulus(1'b1, 1'b0, 16'd10, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd11, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd12, 2'b00, 16'h0);
      idle(4);

      // Read-then-write hazard on the same word
      applyStimulus(1'b0, 1'b1, 16'd5, 2'b11, 16'h0001);
      applyStimulus(1'b1, 1'b0, 16'd5, 2'b00, 16'h0);
      applyStimulus(1'b0, 1'b1, 16'd5, 2'b11, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 16'd5, 2'b00, 16'h0);
      idle(4);

      // Error cases, each followed by a read proving nothing was written
      applyStimulus(1'b0, 1'b1, 16'd7, 2'b11, 16'h7777);
      applyStimulus(1'b1, 1'b1, 16'd7, 2'b11, 16'hBEEF);
      applyStimulus(1'b1, 1'b0, 16'd7, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd1024, 2'b00, 16'h0);
      applyStimulus(1'b0, 1'b1, 16'd2000, 2'b11, 16'hDEAD);
      applyStimulus(1'b1, 1'b0, 16'd976, 2'b00, 16'h0);
      applyStimulus(1'b0, 1'b1, 16'd1027, 2'b11, 16'hCAFE);
      applyStimulus(1'b1, 1'b0, 16'd3, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 2'b00, 16'h0);
      idle(4);

      // Randomized mix concentrated on a few hot addresses to provoke hazards
      for (int t = 0; t < 500; t++) begin
         kind = $urandom_range(0, 9);
         sel  = $urandom_range(0, 9);
         r = (kind <= 3) || (kind == 8);
         w = (kind >= 4 && kind <= 8);
         if (sel <= 4)      a = 16'($urandom_range(0, DEPTH - 1));
         else if (sel <= 7) a = 16'($urandom_range(0, 7));
         else               a = 16'($urandom_range(DEPTH, 65535));
         applyStimulus(r, w, a, 2'($urandom), 16'($urandom));
      end
      idle(4);

      // Reset one cycle after a read: the two-cycle read must vanish
      applyStimulus(1'b0, 1'b1, 16'd10, 2'b11, 16'h5A5A);
      applyStimulus(1'b1, 1'b0, 16'd10, 2'b00, 16'h0);
      doReset(0);
      applyStimulus(1'b1, 1'b0, 16'd10, 2'b00, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'd3, 2'b00, 16'h0);
      idle(6);

      checkVal("rd_queue_lat1_empty", 32'(rd_q[0].size()), 32'd0);
      checkVal("rd_queue_lat2_empty", 32'(rd_q[1].size()), 32'd0);
      checkVal("err_queue_lat1_empty", 32'(err_q[0].size()), 32'd0);
      checkVal("err_queue_lat2_empty", 32'(err_q[1].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
